// File: rtl/rs_pkg.sv
// Shared constants, FSM state type and helpers for the Reed-Solomon (15,9) decoder controller.
package rs_pkg;

  localparam int unsigned SYM_W = 4;
  localparam int unsigned N     = 15;
  localparam int unsigned K     = 9;
  localparam int unsigned NSYN  = 6;
  localparam int unsigned T     = 3;

  typedef enum logic [2:0] {
    StIdle,
    StSyn,
    StBkm,
    StChien,
    StDone
  } rs_state_e;

  function automatic logic [3:0] popcount(input logic [N-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rs_dec_ctrl_if.sv
// Host and decoder-stage handshake bundle for rs_dec_ctrl.
interface rs_dec_ctrl_if import rs_pkg::*; #(
  parameter int unsigned CODE_WIDTH = 60
);

  logic                        en;
  logic [CODE_WIDTH-1:0]       datain;
  logic                        busy;
  logic                        syn_start;
  logic                        bkm_start;
  logic                        chein_start;
  logic                        syn_rdy;
  logic                        bkm_rdy;
  logic                        chein_rdy;
  logic [NSYN-1:0][SYM_W-1:0]  syndrom;
  logic [N-1:0][SYM_W-1:0]     locator;
  logic                        rdy;
  logic [CODE_WIDTH-1:0]       dataout;
  logic [N-1:0]                err_pos;
  logic [3:0]                  err_cnt;
  logic                        uncorr;
  logic                        tmo;

  modport slave (
    input  en, datain, syn_rdy, bkm_rdy, chein_rdy, syndrom, locator,
    output busy, syn_start, bkm_start, chein_start, rdy, dataout, err_pos, err_cnt, uncorr, tmo
  );

  modport master (
    output en, datain, syn_rdy, bkm_rdy, chein_rdy, syndrom, locator,
    input  busy, syn_start, bkm_start, chein_start, rdy, dataout, err_pos, err_cnt, uncorr, tmo
  );

endinterface

// File: rtl/rs_stage_timer.sv
// Per-stage watchdog: counts cycles spent in a decoder stage and flags expiry.
module rs_stage_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // clear marks cycle 0 of a stage; afterwards cnt_q equals the cycle index within the stage.
  assign expire = enable && !clear && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= CW'(1);
    end else if (enable && !expire) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/rs_dec_ctrl.sv
// Sequences syndrome, Berlekamp-Massey and Chien stages for one buffered codeword at a time,
// with a per-stage watchdog and a registered error summary.
module rs_dec_ctrl import rs_pkg::*; #(
  parameter int unsigned CODE_WIDTH = 60,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic          clk,
  input logic          rst,
  rs_dec_ctrl_if.slave bus
);

  rs_state_e             state_q;
  logic [CODE_WIDTH-1:0] buf_q;
  logic [CODE_WIDTH-1:0] dataout_q;
  logic                  busy_q;
  logic                  rdy_q;
  logic                  tmo_q;
  logic                  uncorr_q;
  logic                  syn_start_q;
  logic                  bkm_start_q;
  logic                  chein_start_q;
  logic [N-1:0]          err_pos_q;
  logic [3:0]            err_cnt_q;

  logic [N-1:0]          loc_map;
  logic [3:0]            loc_cnt;
  logic                  in_stage;
  logic                  stage_entry;
  logic                  stage_rdy;
  logic                  stage_exp;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      loc_map[i] = |bus.locator[i];
    end
  end

  assign loc_cnt = popcount(loc_map);

  // Start pulses land on the first cycle of each stage, so they also restart the watchdog.
  assign stage_entry = syn_start_q | bkm_start_q | chein_start_q;
  assign in_stage    = (state_q == StSyn) || (state_q == StBkm) || (state_q == StChien);

  always_comb begin
    stage_rdy = 1'b0;
    unique case (state_q)
      StSyn:   stage_rdy = bus.syn_rdy;
      StBkm:   stage_rdy = bus.bkm_rdy;
      StChien: stage_rdy = bus.chein_rdy;
      default: stage_rdy = 1'b0;
    endcase
  end

  rs_stage_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (stage_entry),
    .enable(in_stage),
    .expire(stage_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      buf_q         <= '0;
      dataout_q     <= '0;
      busy_q        <= 1'b0;
      rdy_q         <= 1'b0;
      tmo_q         <= 1'b0;
      uncorr_q      <= 1'b0;
      syn_start_q   <= 1'b0;
      bkm_start_q   <= 1'b0;
      chein_start_q <= 1'b0;
      err_pos_q     <= '0;
      err_cnt_q     <= '0;
    end else begin
      syn_start_q   <= 1'b0;
      bkm_start_q   <= 1'b0;
      chein_start_q <= 1'b0;
      rdy_q         <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.en) begin
            buf_q       <= bus.datain;
            busy_q      <= 1'b1;
            syn_start_q <= 1'b1;
            tmo_q       <= 1'b0;
            uncorr_q    <= 1'b0;
            err_pos_q   <= '0;
            err_cnt_q   <= '0;
            state_q     <= StSyn;
          end
        end
        StSyn: begin
          if (bus.syn_rdy) begin
            if (bus.syndrom == '0) begin
              rdy_q     <= 1'b1;
              dataout_q <= buf_q;
              state_q   <= StDone;
            end else begin
              bkm_start_q <= 1'b1;
              state_q     <= StBkm;
            end
          end
        end
        StBkm: begin
          if (bus.bkm_rdy) begin
            chein_start_q <= 1'b1;
            state_q       <= StChien;
          end
        end
        StChien: begin
          if (bus.chein_rdy) begin
            // Only reachable with a nonzero syndrome, so zero flagged symbols is uncorrectable.
            err_pos_q <= loc_map;
            err_cnt_q <= loc_cnt;
            uncorr_q  <= (loc_cnt > 4'(T)) || (loc_cnt == 4'd0);
            rdy_q     <= 1'b1;
            dataout_q <= buf_q;
            state_q   <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // A ready in the expiry cycle takes priority over the watchdog.
      if (stage_exp && !stage_rdy) begin
        tmo_q     <= 1'b1;
        uncorr_q  <= 1'b1;
        rdy_q     <= 1'b1;
        dataout_q <= buf_q;
        state_q   <= StDone;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.rdy         = rdy_q;
  assign bus.syn_start   = syn_start_q;
  assign bus.bkm_start   = bkm_start_q;
  assign bus.chein_start = chein_start_q;
  assign bus.dataout     = dataout_q;
  assign bus.err_pos     = err_pos_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.uncorr      = uncorr_q;
  assign bus.tmo         = tmo_q;

endmodule

// File: tb/tb_rs_dec_ctrl.sv
// Self-checking bench for rs_dec_ctrl: directed scenarios plus randomized frames against a
// frame-level reference model of the decode outcome and result timing.
module tb_rs_dec_ctrl;
  import rs_pkg::*;

  localparam int unsigned CW  = 60;
  localparam int          TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_dec_ctrl_if #(.CODE_WIDTH(CW)) bus ();

  rs_dec_ctrl #(
    .CODE_WIDTH(CW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observations from the most recent frame
  int              fr_rdy_cyc;
  int              fr_last_rdy;
  int              fr_entry[3];
  bit              fr_seen[3];
  bit              fr_busy_ok;
  bit              fr_clr_ok;
  logic            fr_rdy_after;
  logic            fr_busy_after;
  logic [CW-1:0]   fr_dout;
  logic [CW-1:0]   fr_dout_start;
  logic [N-1:0]    fr_pos;
  logic [3:0]      fr_cnt;
  logic            fr_unc;
  logic            fr_tmo;
  logic [CW-1:0]   prev_dout;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] rand_word();
    return CW'({$urandom(), $urandom()});
  endfunction

  // Outcome of one frame from the decoding rules; ws = index of a stage that never answers, or -1.
  function automatic void model(input logic [23:0] syn, input logic [59:0] loc, input int ws,
                                output logic [N-1:0] pos, output logic [3:0] cnt,
                                output logic unc, output logic tmo);
    int c;
    c   = 0;
    pos = '0;
    cnt = '0;
    unc = 1'b0;
    tmo = 1'b0;
    if (ws == 0 || (syn != 0 && ws > 0)) begin
      tmo = 1'b1;
      unc = 1'b1;
    end else if (syn != 0) begin
      for (int i = 0; i < N; i++) begin
        if (loc[4*i +: 4] != 4'h0) begin
          pos[i] = 1'b1;
          c++;
        end
      end
      cnt = 4'(c);
      unc = (c > 3) || (c == 0);
    end
  endfunction

  // Drives one frame, emulating the three stage units; dly[s] < 0 means stage s never answers.
  task automatic run_frame(input logic [CW-1:0] data, input logic [23:0] syn,
                           input logic [59:0] loc, input int d0, input int d1, input int d2,
                           input bit stray, input bit mid_en, input logic [CW-1:0] data2);
    int cd[3];
    int dly[3];
    bit start_now[3];
    dly = '{d0, d1, d2};
    cd  = '{-1, -1, -1};
    fr_rdy_cyc  = -1;
    fr_last_rdy = -1;
    fr_entry    = '{-1, -1, -1};
    fr_seen     = '{0, 0, 0};
    fr_busy_ok  = 1'b1;
    fr_clr_ok   = 1'b0;
    fr_rdy_after  = 1'bx;
    fr_busy_after = 1'bx;
    bus.syndrom = syn;
    bus.locator = loc;
    bus.datain  = data;
    bus.en      = 1'b1;
    step();
    for (int cyc = 0; cyc < 4 * TMO; cyc++) begin
      bus.en = 1'b0; bus.syn_rdy = 1'b0; bus.bkm_rdy = 1'b0; bus.chein_rdy = 1'b0;
      if (cyc == 0) begin
        fr_dout_start = bus.dataout;
        fr_clr_ok = (bus.err_pos == '0) && (bus.err_cnt == 4'd0) && !bus.tmo && !bus.uncorr;
      end
      if (bus.busy !== 1'b1) fr_busy_ok = 1'b0;
      if (bus.rdy === 1'b1) begin
        fr_rdy_cyc = cyc;
        fr_dout = bus.dataout; fr_pos = bus.err_pos; fr_cnt = bus.err_cnt;
        fr_unc = bus.uncorr; fr_tmo = bus.tmo;
        break;
      end
      start_now = '{bus.syn_start, bus.bkm_start, bus.chein_start};
      for (int s = 0; s < 3; s++) begin
        if (start_now[s]) begin
          fr_seen[s] = 1'b1; fr_entry[s] = cyc; cd[s] = dly[s];
        end
        if (cd[s] == 0) begin
          fr_last_rdy = cyc;
          case (s)
            0:       bus.syn_rdy = 1'b1;
            1:       bus.bkm_rdy = 1'b1;
            default: bus.chein_rdy = 1'b1;
          endcase
        end
        if (cd[s] >= 0) cd[s]--;
      end
      if (stray && cyc == 1) begin
        bus.bkm_rdy = 1'b1; bus.chein_rdy = 1'b1;
      end
      if (mid_en && cyc == 2) begin
        bus.en = 1'b1; bus.datain = data2;
      end
      step();
    end
    bus.en = 1'b0; bus.syn_rdy = 1'b0; bus.bkm_rdy = 1'b0; bus.chein_rdy = 1'b0;
    if (fr_rdy_cyc >= 0) begin
      step();
      fr_rdy_after  = bus.rdy;
      fr_busy_after = bus.busy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({bus.busy, bus.rdy, bus.syn_start, bus.bkm_start, bus.chein_start, bus.tmo, bus.uncorr,
         bus.err_pos, bus.err_cnt, bus.dataout} !== '0)
      $display("FAIL reset_outputs: got busy=%b rdy=%b tmo=%b unc=%b pos=%h cnt=%0d dout=%h, want all 0",
               bus.busy, bus.rdy, bus.tmo, bus.uncorr, bus.err_pos, bus.err_cnt, bus.dataout);
    else n_pass++;
    rst = 1'b0;
    prev_dout = '0;
    step();
  endtask

  task automatic test_zero_error();
    logic [CW-1:0] d;
    d = rand_word();
    run_frame(d, 24'h0, 60'h000_0000_0000_0F00, 5, 1, 1, 1'b0, 1'b0, '0);
    n_checks++;
    if (fr_rdy_cyc !== 6) $display("FAIL zero_latency: got cycle %0d want 6", fr_rdy_cyc);
    else n_pass++;
    n_checks++;
    if (fr_dout !== d) $display("FAIL zero_dataout: got %h want %h", fr_dout, d);
    else n_pass++;
    n_checks++;
    if ({fr_pos, fr_cnt, fr_unc, fr_tmo} !== '0)
      $display("FAIL zero_result: got pos=%h cnt=%0d unc=%b tmo=%b want all 0",
               fr_pos, fr_cnt, fr_unc, fr_tmo);
    else n_pass++;
    n_checks++;
    if (fr_seen[1] || fr_seen[2])
      $display("FAIL zero_skip: got bkm_start=%b chein_start=%b want 0 0", fr_seen[1], fr_seen[2]);
    else n_pass++;
    n_checks++;
    if ({fr_rdy_after, fr_busy_after} !== 2'b00)
      $display("FAIL zero_rdy_width: got rdy=%b busy=%b after rdy want 0 0",
               fr_rdy_after, fr_busy_after);
    else n_pass++;
    prev_dout = d;
  endtask

  task automatic test_two_errors();
    logic [CW-1:0] d;
    logic [59:0]   loc;
    d = rand_word();
    loc = '0; loc[8 +: 4] = 4'h5; loc[28 +: 4] = 4'h9;
    run_frame(d, 24'h030000, loc, 2, 3, 4, 1'b0, 1'b0, '0);
    n_checks++;
    if (fr_dout_start !== prev_dout)
      $display("FAIL hold_dataout: got %h want %h", fr_dout_start, prev_dout);
    else n_pass++;
    n_checks++;
    if ({fr_pos, fr_cnt, fr_unc} !== {15'h0084, 4'd2, 1'b0})
      $display("FAIL two_err: got pos=%h cnt=%0d unc=%b want 0084 2 0", fr_pos, fr_cnt, fr_unc);
    else n_pass++;
    n_checks++;
    if (fr_rdy_cyc !== fr_last_rdy + 1 || fr_rdy_cyc < 0)
      $display("FAIL two_err_latency: got cycle %0d want %0d", fr_rdy_cyc, fr_last_rdy + 1);
    else n_pass++;
    prev_dout = d;
  endtask

  task automatic test_four_errors();
    logic [CW-1:0] d;
    logic [59:0]   loc;
    d = rand_word();
    loc = '0; loc[0 +: 4] = 4'h3; loc[4 +: 4] = 4'h1; loc[20 +: 4] = 4'hA; loc[36 +: 4] = 4'hF;
    run_frame(d, 24'h100001, loc, 1, 1, 1, 1'b0, 1'b0, '0);
    n_checks++;
    if ({fr_pos, fr_cnt, fr_unc, fr_tmo} !== {15'h0223, 4'd4, 1'b1, 1'b0})
      $display("FAIL four_err: got pos=%h cnt=%0d unc=%b tmo=%b want 0223 4 1 0",
               fr_pos, fr_cnt, fr_unc, fr_tmo);
    else n_pass++;
    prev_dout = d;
  endtask

  task automatic test_timeout();
    logic [CW-1:0] d;
    logic [59:0]   loc;
    d = rand_word();
    loc = '0; loc[12 +: 4] = 4'h7;
    run_frame(d, 24'h000020, loc, 1, -1, 1, 1'b0, 1'b0, '0);
    n_checks++;
    if ({fr_tmo, fr_unc, fr_cnt} !== {1'b1, 1'b1, 4'd0})
      $display("FAIL tmo_flags: got tmo=%b unc=%b cnt=%0d want 1 1 0", fr_tmo, fr_unc, fr_cnt);
    else n_pass++;
    n_checks++;
    if (fr_rdy_cyc !== fr_entry[1] + TMO || fr_entry[1] < 0)
      $display("FAIL tmo_latency: got cycle %0d want %0d", fr_rdy_cyc, fr_entry[1] + TMO);
    else n_pass++;
    n_checks++;
    if (fr_seen[2] !== 1'b0) $display("FAIL tmo_no_chein: got chein_start=1 want 0");
    else n_pass++;
    prev_dout = d;
    // bkm_rdy lands exactly in the expiry cycle
    d = rand_word();
    run_frame(d, 24'h000020, loc, 1, TMO - 1, 2, 1'b0, 1'b0, '0);
    n_checks++;
    if (fr_clr_ok !== 1'b1) $display("FAIL clear_on_accept: got stale flags=1 want 0");
    else n_pass++;
    n_checks++;
    if ({fr_tmo, fr_seen[2], fr_pos, fr_cnt, fr_unc} !== {1'b0, 1'b1, 15'h0008, 4'd1, 1'b0})
      $display("FAIL race_ready_wins: got tmo=%b chein=%b pos=%h cnt=%0d unc=%b want 0 1 0008 1 0",
               fr_tmo, fr_seen[2], fr_pos, fr_cnt, fr_unc);
    else n_pass++;
    prev_dout = d;
  endtask

  task automatic test_busy_en();
    logic [CW-1:0] d, d2;
    logic [59:0]   loc;
    d  = rand_word();
    d2 = ~d;
    loc = '0; loc[56 +: 4] = 4'h2;
    run_frame(d, 24'h400000, loc, 4, 2, 3, 1'b1, 1'b1, d2);
    n_checks++;
    if (fr_dout !== d) $display("FAIL busy_en_ignored: got %h want %h", fr_dout, d);
    else n_pass++;
    n_checks++;
    if ({fr_pos, fr_cnt, fr_busy_ok} !== {15'h4000, 4'd1, 1'b1} || fr_rdy_cyc !== fr_last_rdy + 1)
      $display("FAIL stray_ready: got pos=%h cnt=%0d busy_ok=%b cyc=%0d want 4000 1 1 %0d",
               fr_pos, fr_cnt, fr_busy_ok, fr_rdy_cyc, fr_last_rdy + 1);
    else n_pass++;
    prev_dout = d;
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] d;
    logic          got;
    d = rand_word();
    bus.syndrom = 24'h000100;
    bus.locator = 60'h1;
    bus.datain  = d;
    bus.en      = 1'b1;
    step();
    bus.en = 1'b0; bus.syn_rdy = 1'b1;
    step();
    bus.syn_rdy = 1'b0;
    n_checks++;
    if (bus.bkm_start !== 1'b1) $display("FAIL mid_bkm_start: got %b want 1", bus.bkm_start);
    else n_pass++;
    bus.bkm_rdy = 1'b1;
    step();
    bus.bkm_rdy = 1'b0;
    n_checks++;
    if (bus.chein_start !== 1'b1) $display("FAIL mid_chein_start: got %b want 1", bus.chein_start);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.rdy, bus.syn_start, bus.bkm_start, bus.chein_start, bus.tmo, bus.uncorr,
         bus.err_pos, bus.err_cnt, bus.dataout} !== '0)
      $display("FAIL mid_reset_outputs: got busy=%b dout=%h want all 0", bus.busy, bus.dataout);
    else n_pass++;
    step();
    rst = 1'b0;
    bus.chein_rdy = 1'b1;
    step();
    bus.chein_rdy = 1'b0;
    got = 1'b0;
    repeat (4) begin
      if (bus.rdy !== 1'b0 || bus.busy !== 1'b0) got = 1'b1;
      step();
    end
    n_checks++;
    if (got !== 1'b0) $display("FAIL mid_reset_no_rdy: got rdy/busy activity=1 want 0");
    else n_pass++;
    prev_dout = '0;
    d = rand_word();
    run_frame(d, 24'h0, 60'h0, 3, 1, 1, 1'b0, 1'b0, '0);
    n_checks++;
    if (fr_dout !== d || fr_rdy_cyc !== 4)
      $display("FAIL post_reset_frame: got dout=%h cyc=%0d want %h 4", fr_dout, fr_rdy_cyc, d);
    else n_pass++;
    prev_dout = d;
  endtask

  task automatic test_random();
    logic [CW-1:0]   d, d2;
    logic [23:0]     syn;
    logic [59:0]     loc;
    logic [N-1:0]    e_pos;
    logic [3:0]      e_cnt;
    logic            e_unc, e_tmo;
    int              ws, dl[3], e_lat;
    bit              stray, mid_en;
    for (int f = 0; f < 30; f++) begin
      d   = rand_word();
      d2  = rand_word();
      syn = ($urandom_range(0, 2) == 0) ? 24'h0 : 24'($urandom_range(1, 24'hFF_FFFF));
      loc = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) loc[4*i +: 4] = 4'($urandom_range(1, 15));
      end
      ws = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
      for (int s = 0; s < 3; s++) dl[s] = (s == ws) ? -1 : int'($urandom_range(1, 6));
      stray  = 1'($urandom_range(0, 1));
      mid_en = 1'($urandom_range(0, 1));
      model(syn, loc, ws, e_pos, e_cnt, e_unc, e_tmo);
      run_frame(d, syn, loc, dl[0], dl[1], dl[2], stray, mid_en, d2);
      e_lat = e_tmo ? fr_entry[ws] + TMO : fr_last_rdy + 1;
      n_checks++;
      if (fr_rdy_cyc < 0 || fr_rdy_cyc !== e_lat)
        $display("FAIL rnd%0d_latency: got cycle %0d want %0d", f, fr_rdy_cyc, e_lat);
      else n_pass++;
      n_checks++;
      if (fr_dout !== d) $display("FAIL rnd%0d_dataout: got %h want %h", f, fr_dout, d);
      else n_pass++;
      n_checks++;
      if ({fr_pos, fr_cnt, fr_unc, fr_tmo} !== {e_pos, e_cnt, e_unc, e_tmo})
        $display("FAIL rnd%0d_result: got pos=%h cnt=%0d unc=%b tmo=%b want %h %0d %b %b",
                 f, fr_pos, fr_cnt, fr_unc, fr_tmo, e_pos, e_cnt, e_unc, e_tmo);
      else n_pass++;
      n_checks++;
      if (fr_seen[1] !== (syn != 0 && ws != 0) || fr_seen[2] !== (syn != 0 && (ws < 0 || ws == 2)))
        $display("FAIL rnd%0d_starts: got bkm=%b chein=%b", f, fr_seen[1], fr_seen[2]);
      else n_pass++;
      n_checks++;
      if ({fr_busy_ok, fr_clr_ok, fr_rdy_after, fr_busy_after} !== 4'b1100)
        $display("FAIL rnd%0d_handshake: got busy_ok=%b clr=%b rdy_after=%b busy_after=%b want 1 1 0 0",
                 f, fr_busy_ok, fr_clr_ok, fr_rdy_after, fr_busy_after);
      else n_pass++;
      n_checks++;
      if (fr_dout_start !== prev_dout)
        $display("FAIL rnd%0d_hold: got %h want %h", f, fr_dout_start, prev_dout);
      else n_pass++;
      prev_dout = d;
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.datain = '0; bus.syn_rdy = 1'b0; bus.bkm_rdy = 1'b0; bus.chein_rdy = 1'b0;
    bus.syndrom = '0; bus.locator = '0;
    test_reset();
    test_zero_error();
    test_two_errors();
    test_four_errors();
    test_timeout();
    test_busy_en();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/rs_dec_ctrl.md
RS_DEC_CTRL -- requirements
Module: rs_dec_ctrl

Interface
REQ-001 Parameter CODE_WIDTH, default 60, SHALL set the codeword width (15 symbols x 4 bits).
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum cycles to wait for any stage ready.
REQ-003 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 en  in  1  SHALL be the codeword-valid strobe, accepted only when busy=0.
REQ-006 datain  in  CODE_WIDTH  SHALL be the received codeword, sampled with en.
REQ-007 busy  out  1  SHALL be high from the cycle after acceptance through the rdy cycle.
REQ-008 syn_start / bkm_start / chein_start  out  1 each  SHALL be single-cycle start pulses to the syndrome, Berlekamp-Massey and Chien units.
REQ-009 syn_rdy / bkm_rdy / chein_rdy  in  1 each  SHALL be the stage-done pulses.
REQ-010 syndrom  in  6x4  SHALL be the syndrome vector, valid with syn_rdy.
REQ-011 locator  in  15x4  SHALL be the Chien result, valid with chein_rdy; a nonzero entry i marks symbol i in error.
REQ-012 rdy  out  1  SHALL be a one-cycle result-valid pulse.
REQ-013 dataout  out  CODE_WIDTH  SHALL be the buffered codeword, held stable until the next rdy.
REQ-014 err_pos  out  15  SHALL be the bitmap of flagged error positions.
REQ-015 err_cnt  out  4  SHALL be the popcount of err_pos.
REQ-016 uncorr  out  1  SHALL flag err_cnt > 3 or err_cnt = 0 with a nonzero syndrome.
REQ-017 tmo  out  1  SHALL flag a stage watchdog expiry.

Function
REQ-018 FSM states SHALL be IDLE, SYN, BKM, CHIEN, DONE.
REQ-019 IDLE: on en, SHALL capture datain into the buffer, pulse syn_start next cycle, and enter SYN.
REQ-020 en while busy=1 SHALL be ignored; the buffer is not overwritten.
REQ-021 SYN: on syn_rdy with all syndromes zero, SHALL go to DONE with err_pos=0, err_cnt=0, uncorr=0 (BKM/Chien skipped).
REQ-022 SYN: on syn_rdy with any nonzero syndrome, SHALL pulse bkm_start next cycle and enter BKM.
REQ-023 BKM: on bkm_rdy, SHALL pulse chein_start next cycle and enter CHIEN.
REQ-024 CHIEN: on chein_rdy, SHALL register err_pos/err_cnt/uncorr and enter DONE.
REQ-025 DONE SHALL assert rdy for exactly one cycle, then return to IDLE with busy=0.
REQ-026 Latency: rdy SHALL occur exactly one cycle after the final stage ready is sampled.
REQ-027 A stage ready pulse arriving in a state that does not await it SHALL be ignored.
REQ-028 The watchdog SHALL count cycles in SYN/BKM/CHIEN, clearing on each state entry; at TIMEOUT it SHALL go to DONE with tmo=1, uncorr=1.
REQ-029 A ready pulse in the same cycle as watchdog expiry SHALL win; tmo stays 0.
REQ-030 tmo/uncorr/err_* SHALL be cleared on each new acceptance.

Reset
REQ-031 rst SHALL force IDLE asynchronously, with busy, rdy, all start pulses, tmo, uncorr, err_pos, err_cnt and dataout set to 0.
REQ-032 Reset mid-operation SHALL abort the frame with no rdy; stage ready pulses arriving afterwards are ignored in IDLE.

Structure
REQ-033 Package rs_pkg SHALL hold SYM_W=4, N=15, K=9, NSYN=6, T=3 and the FSM state enum.
REQ-034 The watchdog SHALL be a sub-module rs_stage_timer (clear, enable, expire output).

Verification
REQ-035 Zero-error codeword; syn_rdy with all syndromes 0 after 5 cycles -> rdy 1 cycle later, dataout=datain, err_cnt=0, no bkm_start.
REQ-036 Nonzero syndrome; locator[2], locator[7] nonzero -> err_pos=0x0084, err_cnt=2, uncorr=0.
REQ-037 Four locator entries nonzero -> err_cnt=4, uncorr=1.
REQ-038 Withhold bkm_rdy -> tmo=1, uncorr=1 and rdy exactly TIMEOUT cycles after BKM entry; bkm_rdy on the expiry cycle -> tmo=0.
REQ-039 en pulsed in SYN with different data -> ignored; dataout equals the first word.
REQ-040 rst asserted in CHIEN, then chein_rdy -> no rdy, all outputs 0, next en processed normally.
